// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   W      operand width
//   STEPS  radix-2 iterations per multiply/divide
//   mdop_e operation encodings presented on mdop
//   state_e FSM state encoding
//   mag()  two's-complement magnitude helper
package mdu_pkg;

  localparam int W     = 32;
  localparam int STEPS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [W-1:0] mag(input logic neg, input logic [W-1:0] x);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration shared by multiply and divide.
//   is_div   1 = restoring-divide step, 0 = shift-add multiply step
//   acc      64-bit working register
//              multiply: {partial product high, multiplier bits not yet consumed}
//              divide:   {partial remainder, dividend/quotient bits}
//   m        multiplicand (multiply) or divisor (divide) magnitude
//   acc_nxt  working register after this step
module mdu_step
  import mdu_pkg::*;
(
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   m,
  output logic [2*W-1:0] acc_nxt
);

  logic [W:0]   sum;
  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] dif;

  always_comb begin
    // Multiply: add m when the multiplier LSB is set, then shift right with carry.
    sum    = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? m : '0)};
    // Divide: shifted remainder is 33 bits; once it is >= m the true
    // difference is < 2^32, so a 32-bit subtract is exact.
    rem_sh = acc[2*W-1:W-1];
    ge     = (rem_sh >= {1'b0, m});
    dif    = rem_sh[W-1:0] - m;
    if (!is_div)
      acc_nxt = {sum, acc[W-1:1]};
    else if (ge)
      acc_nxt = {dif, acc[W-2:0], 1'b1};
    else
      acc_nxt = {acc[2*W-2:0], 1'b0};
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MIPS-style HI/LO multiply/divide unit.
//   CLK, RST        clock, async active-high reset
//   start, mdop     issue request and operation code (mdu_pkg::mdop_e)
//   opA, opB        rs / rt operands
//   rd_req          MFHI/MFLO in EX this cycle
//   busy            multi-cycle operation in flight
//   stall           pipeline hold = busy & (rd_req | start)
//   done            one-cycle pulse after HI/LO updated by a mult/div
//   HI, LO          result registers
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write here directly
// CALC  | one setup cycle (operand magnitudes) then 32 radix-2 steps
// FIX   | sign correction and HI/LO write; also the divide-by-zero write
module mdu_seq
  import mdu_pkg::*;
#(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [2:0]    mdop,
  input  logic [W-1:0]  opA,
  input  logic [W-1:0]  opB,
  input  logic          rd_req,
  output logic          busy,
  output logic          stall,
  output logic          done,
  output logic [W-1:0]  HI,
  output logic [W-1:0]  LO
);

  // Counter runs down from STEPS+1; the extra top count is the setup cycle
  // that converts the latched operands to magnitudes.
  localparam logic [5:0] SETUP_CNT = 6'(STEPS + 1);

  state_e         state;
  logic [5:0]     cnt;
  logic [W-1:0]   opa_q, opb_q, m_q;
  logic           sa_q, sb_q, is_div_q, div0_q;
  logic [2*W-1:0] acc, acc_nxt, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  logic           is_div_in, signed_in;

  assign is_div_in = (mdop == OP_DIV) || (mdop == OP_DIVU);
  assign signed_in = (mdop == OP_MULT) || (mdop == OP_DIV);
  assign stall     = busy & (rd_req | start);

  assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];

  mdu_step u_step (
    .is_div  (is_div_q),
    .acc     (acc),
    .m       (m_q),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      m_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (mdop)
              OP_MTHI: HI <= opA;
              OP_MTLO: LO <= opA;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                opa_q    <= opA;
                opb_q    <= opB;
                sa_q     <= signed_in & opA[W-1];
                sb_q     <= signed_in & opB[W-1];
                is_div_q <= is_div_in;
                if (is_div_in && (opB == '0)) begin
                  // Divide by zero goes straight to FIX without raising busy.
                  div0_q <= 1'b1;
                  state  <= FIX;
                end else begin
                  div0_q <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= SETUP_CNT;
                  state  <= CALC;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          cnt <= cnt - 6'd1;
          if (cnt == SETUP_CNT) begin
            acc <= {{W{1'b0}}, (is_div_q ? mag(sa_q, opa_q) : mag(sb_q, opb_q))};
            m_q <= is_div_q ? mag(sb_q, opb_q) : mag(sa_q, opa_q);
          end else begin
            acc <= acc_nxt;
          end
          if (cnt == 6'd1)
            state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (div0_q) begin
            HI <= opa_q;
            LO <= DIV0_LO;
          end else if (is_div_q) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            {HI, LO} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] opA = '0, opB = '0;
  logic        rd_req = 1'b0;
  logic        busy, stall, done;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mdu_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .mdop(mdop), .opA(opA), .opB(opB),
    .rd_req(rd_req), .busy(busy), .stall(stall), .done(done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge (E0).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    start = 1'b1; mdop = op; opA = a; opB = b;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Full multi-cycle op: busy span, HI/LO hold, done pulse and result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int n;
    bit moved;
    hi0 = HI; lo0 = LO; n = 0; moved = 0;
    issue(op, a, b);
    chk({tag, " busy_e0"}, busy, 1);
    while (busy && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (busy && (HI !== hi0 || LO !== lo0)) moved = 1;
    end
    chk({tag, " busy_cycles"}, n, 34);
    chk({tag, " hold"}, moved, 0);
    chk({tag, " done"}, done, 1);
    chk({tag, " hi"}, HI, exp_hi);
    chk({tag, " lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    bit seen;
    bit moved;
    int bad_stall;

    // Reset state, with start held so the first free edge can accept it.
    start = 1'b1; mdop = OP_MTLO; opA = 32'h33;
    #12;
    chk("rst hi", HI, 0);
    chk("rst lo", LO, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1; start = 1'b0;
    chk("first_edge mtlo", LO, 32'h33);
    chk("first_edge busy", busy, 0);

    issue(OP_MTHI, 32'hA, 0);
    chk("mthi hi", HI, 32'hA);
    chk("mthi done", done, 0);
    chk("mthi busy", busy, 0);
    rd_req = 1'b1; #1;
    chk("idle stall", stall, 0);
    rd_req = 1'b0;

    run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    @(posedge CLK); #1;
    chk("mult_min done_pulse", done, 0);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_m7_2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    run_op("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // Divide by zero.
    issue(OP_DIVU, 32'h1234, 32'h0);
    chk("div0 busy_e0", busy, 0);
    chk("div0 done_e0", done, 0);
    @(posedge CLK); #1;
    chk("div0 busy_e1", busy, 0);
    chk("div0 done_e1", done, 1);
    chk("div0 hi", HI, 32'h1234);
    chk("div0 lo", LO, 32'hFFFFFFFF);
    @(posedge CLK); #1;
    chk("div0 done_off", done, 0);

    // MULTU with rd_req from cycle 5: stall held, HI/LO frozen until E34.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0; moved = 0; bad_stall = 0;
    while (busy && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (n == 5) begin rd_req = 1'b1; #1; end
      if (busy && n >= 5 && !stall) bad_stall++;
      if (busy && (HI !== 32'h1234 || LO !== 32'hFFFFFFFF)) moved = 1;
    end
    chk("multu busy_cycles", n, 34);
    chk("multu stall_low", bad_stall, 0);
    chk("multu hold", moved, 0);
    chk("multu stall_after", stall, 0);
    chk("multu hi", HI, 32'hFFFFFFFE);
    chk("multu lo", LO, 32'h00000001);
    rd_req = 1'b0;

    // start while busy is ignored but raises stall.
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; mdop = OP_MTHI; opA = 32'h99;
    #1;
    chk("busy_start stall", stall, 1);
    @(posedge CLK); #1; start = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(posedge CLK); #1; n++; end
    chk("busy_start hi", HI, 32'h0);
    chk("busy_start lo", LO, 32'd15);

    // Back-to-back: new op issued during the done cycle is accepted.
    run_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 32'h0, 32'd6);
    issue(OP_MTHI, 32'h77, 0);
    chk("done_accept hi", HI, 32'h77);
    chk("done_accept lo", LO, 32'd6);

    // Reset in the middle of CALC.
    issue(OP_MTHI, 32'hA, 0);
    issue(OP_MTLO, 32'hB, 0);
    issue(OP_MULT, 32'd1234, 32'd5678);
    repeat (10) @(posedge CLK);
    #2; RST = 1'b1; #1;
    chk("midrst hi", HI, 0);
    chk("midrst lo", LO, 0);
    chk("midrst busy", busy, 0);
    @(negedge CLK); RST = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge CLK); #1; if (done || busy) seen = 1; end
    chk("midrst no_done", seen, 0);
    chk("midrst lo_held", LO, 0);
    issue(OP_MTLO, 32'd5, 0);
    chk("midrst mtlo", LO, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
